// File: rtl/framebuffer_scanout_if.sv
// Framebuffer read port plus pixel stream bundle for framebuffer_scanout.
// FB_SCANOUT_PALETTE_EN adds the out_rgb stream field.
interface framebuffer_scanout_if #(
  parameter int ADDR_W = 15
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_pixel;
  logic              out_sof;
  logic              out_eol;
`ifdef FB_SCANOUT_PALETTE_EN
  logic [23:0]       out_rgb;
`endif

  // master: the scanout engine; slave: framebuffer memory and pixel sink
  modport master (
    input  rd_data, out_ready,
`ifdef FB_SCANOUT_PALETTE_EN
    output out_rgb,
`endif
    output rd_en, rd_addr, out_valid, out_pixel, out_sof, out_eol
  );

  modport slave (
    output rd_data, out_ready,
`ifdef FB_SCANOUT_PALETTE_EN
    input  out_rgb,
`endif
    input  rd_en, rd_addr, out_valid, out_pixel, out_sof, out_eol
  );
endinterface

// File: rtl/framebuffer_scanout.sv
// Streams a WIDTHxHEIGHT gb_color_t frame from a 1-cycle-latency framebuffer to a valid/ready sink.
// Optional macro FB_SCANOUT_PALETTE_EN adds a registered DMG palette RGB output.
module framebuffer_scanout #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144,
  parameter int ADDR_W = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  output logic                 busy,
  output logic                 frame_done,
  framebuffer_scanout_if.master bus
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int XW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [XW-1:0]     LAST_X    = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     LAST_Y    = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  typedef struct packed {
`ifdef FB_SCANOUT_PALETTE_EN
    logic [23:0] rgb;
`endif
    logic [1:0]  pix;
    logic        sof;
    logic        eol;
  } entry_t;

`ifdef FB_SCANOUT_PALETTE_EN
  function automatic logic [23:0] dmg_rgb(input logic [1:0] c);
    logic [23:0] rgb;
    case (c)
      2'd0:    rgb = 24'hE0F8D0;
      2'd1:    rgb = 24'h88C070;
      2'd2:    rgb = 24'h346856;
      default: rgb = 24'h081820;
    endcase
    return rgb;
  endfunction
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_pending;
  logic              r_inflight;
  logic              r_if_sof;
  logic              r_if_eol;
  logic [1:0]        r_occ;
  entry_t            r_slot0;
  entry_t            r_slot1;
  logic              r_done;

  logic              w_rd_en;
  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_credit;
  logic              w_drain_done;
  entry_t            w_new;

  // Credit counts what the buffer will hold after this cycle's capture and pop,
  // so a read can be issued alongside a transfer and the stream runs without bubbles.
  assign w_pop        = (r_occ != 2'd0) && bus.out_ready;
  assign w_push       = r_inflight;
  assign w_credit     = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_drain_done = (r_state == S_DRAIN) && (w_credit == 3'd0);

  always_comb begin
    w_new     = '0;
    w_new.pix = bus.rd_data;
    w_new.sof = r_if_sof;
    w_new.eol = r_if_eol;
`ifdef FB_SCANOUT_PALETTE_EN
    w_new.rgb = dmg_rgb(bus.rd_data);
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start || r_pending) w_state_nxt = S_READ;
      end
      S_READ: begin
        if (w_credit < 3'd2) begin
          w_rd_en = 1'b1;
          if (r_addr == LAST_ADDR) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_drain_done;
      // One-deep request queue; a start seen while idle launches directly instead
      if (r_state == S_IDLE)
        r_pending <= 1'b0;
      else if (frame_start)
        r_pending <= 1'b1;
    end
  end

  // Read issue stage: linear address plus x/y position for sof/eol tagging
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_inflight <= 1'b0;
      r_if_sof   <= 1'b0;
      r_if_eol   <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      r_if_sof   <= w_rd_en && (r_x == '0) && (r_y == '0);
      r_if_eol   <= w_rd_en && (r_x == LAST_X);
      if (r_state == S_IDLE) begin
        r_addr <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end else if (w_rd_en) begin
        r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
        if (r_x == LAST_X) begin
          r_x <= '0;
          r_y <= (r_y == LAST_Y) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  // Capture stage: two-entry output buffer, slot0 is the presented pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ   <= 2'd0;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_slot0 <= w_new;
          else               r_slot1 <= w_new;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_slot0 <= r_slot1;
          r_occ   <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_slot0 <= w_new;
          end else begin
            r_slot0 <= r_slot1;
            r_slot1 <= w_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr   = r_addr;
  assign bus.out_valid = (r_occ != 2'd0);
  assign bus.out_pixel = r_slot0.pix;
  assign bus.out_sof   = r_slot0.sof;
  assign bus.out_eol   = r_slot0.eol;
`ifdef FB_SCANOUT_PALETTE_EN
  assign bus.out_rgb   = r_slot0.rgb;
`endif
  assign busy          = (r_state != S_IDLE);
  assign frame_done    = r_done;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout on a reduced 32x8 frame; a negedge monitor
// pops expected pixels on every handshake and checks hold-while-stalled and frame_done.
module tb_framebuffer_scanout;

  localparam int TW = 32;
  localparam int TH = 8;
  localparam int AW = 15;
  localparam int N  = TW * TH;

  typedef struct packed {
    logic [1:0] pix;
    logic       sof;
    logic       eol;
    logic       fin;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic frame_start;
  logic busy;
  logic frame_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   hs_count = 0;
  exp_t q[$];

  logic        p_stall = 1'b0;
  logic        p_final = 1'b0;
  logic [31:0] p_obs   = '0;

  framebuffer_scanout_if #(.ADDR_W(AW)) bus ();

  framebuffer_scanout #(
    .WIDTH (TW),
    .HEIGHT(TH),
    .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Framebuffer model: fb[a] = a % 4, one-cycle read latency
  initial bus.rd_data = 2'd0;
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= bus.rd_addr[1:0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] pal(input logic [1:0] c);
    case (c)
      2'd0:    return 24'hE0F8D0;
      2'd1:    return 24'h88C070;
      2'd2:    return 24'h346856;
      default: return 24'h081820;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input exp_t e);
    logic [31:0] w;
    w = {28'd0, e.pix, e.sof, e.eol};
`ifdef FB_SCANOUT_PALETTE_EN
    w[27:4] = pal(e.pix);
`endif
    return w;
  endfunction

  function automatic logic [31:0] obs_word();
    logic [31:0] w;
    w = {28'd0, bus.out_pixel, bus.out_sof, bus.out_eol};
`ifdef FB_SCANOUT_PALETTE_EN
    w[27:4] = bus.out_rgb;
`endif
    return w;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int a = 0; a < N; a++) begin
      e.pix = 2'(a % 4);
      e.sof = (a == 0);
      e.eol = ((a % TW) == TW - 1);
      e.fin = (a == N - 1);
      q.push_back(e);
    end
  endtask

  // Monitor: sampled on the falling edge, transfers happen on the next rising edge
  always @(negedge clk) begin
    if (reset) begin
      p_stall = 1'b0;
      p_final = 1'b0;
    end else begin
      if (p_stall) check_eq("hold", {bus.out_valid, obs_word()}, {1'b1, p_obs});
      if (frame_done || p_final) check_eq("frame_done", 32'(frame_done), 32'(p_final));
      p_final = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        hs_count++;
        if (q.size() == 0) begin
          check_eq("extra_pixel", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_eq("pixel", obs_word(), exp_word(e));
          p_final = e.fin;
        end
      end
      p_stall = bus.out_valid && !bus.out_ready;
      p_obs   = obs_word();
    end
  end

  task automatic check_idle(input string pfx);
    check_eq({pfx, "_busy"},       32'(busy),          32'd0);
    check_eq({pfx, "_done"},       32'(frame_done),    32'd0);
    check_eq({pfx, "_rd_en"},      32'(bus.rd_en),     32'd0);
    check_eq({pfx, "_rd_addr"},    32'(bus.rd_addr),   32'd0);
    check_eq({pfx, "_out_valid"},  32'(bus.out_valid), 32'd0);
    check_eq({pfx, "_out_pixel"},  32'(bus.out_pixel), 32'd0);
    check_eq({pfx, "_out_sof"},    32'(bus.out_sof),   32'd0);
    check_eq({pfx, "_out_eol"},    32'(bus.out_eol),   32'd0);
`ifdef FB_SCANOUT_PALETTE_EN
    check_eq({pfx, "_out_rgb"},    32'(bus.out_rgb),   32'd0);
`endif
  endtask

  task automatic pulse_start(input bit push);
    frame_start = 1'b1;
    if (push) push_frame();
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_hs(input int n, input int limit);
    int cnt;
    cnt = 0;
    while (hs_count < n && cnt < limit) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (hs_count < n) check_eq("timeout_hs", 32'(hs_count), 32'(n));
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk); #1;
      if (frame_done) seen = 1'b1;
    end
    if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset       = 1'b1;
    frame_start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame latency and full raster order
    pulse_start(1'b1);
    check_eq("t1_rd_en_c1",  32'(bus.rd_en),     32'd1);
    check_eq("t1_addr_c1",   32'(bus.rd_addr),   32'd0);
    check_eq("t1_busy",      32'(busy),          32'd1);
    check_eq("t1_valid_c1",  32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("t1_valid_c2",  32'(bus.out_valid), 32'd0);
    check_eq("t1_addr_c2",   32'(bus.rd_addr),   32'd1);
    @(posedge clk); #1;
    check_eq("t1_valid_c3",  32'(bus.out_valid), 32'd1);
    check_eq("t1_sof_c3",    32'(bus.out_sof),   32'd1);
    wait_done("t1", 4 * N);
    check_eq("t1_left", 32'(q.size()), 32'd0);
    @(posedge clk); #1;

    // Back-pressure: long stall, then toggling ready
    base = hs_count;
    pulse_start(1'b1);
    wait_hs(base + 50, 4 * N);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 4 || i == 19) begin
        check_eq("t2_rd_en_stalled", 32'(bus.rd_en),     32'd0);
        check_eq("t2_valid_stalled", 32'(bus.out_valid), 32'd1);
      end
    end
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 8 * N && !seen; i++) begin
        bus.out_ready = ~bus.out_ready;
        @(posedge clk); #1;
        if (frame_done) seen = 1'b1;
      end
      if (!seen) check_eq("t2_timeout", 32'd0, 32'd1);
    end
    bus.out_ready = 1'b1;
    check_eq("t2_left", 32'(q.size()), 32'd0);
    @(posedge clk); #1;

    // Pending request: one accepted, the second ignored
    base = hs_count;
    pulse_start(1'b1);
    wait_hs(base + 40, 4 * N);
    pulse_start(1'b1);
    wait_hs(base + 70, 4 * N);
    pulse_start(1'b0);
    wait_done("t3a", 4 * N);
    check_eq("t3_gap_busy",  32'(busy),      32'd0);
    check_eq("t3_gap_rd_en", 32'(bus.rd_en), 32'd0);
    @(posedge clk); #1;
    check_eq("t3_restart_busy",  32'(busy),        32'd1);
    check_eq("t3_restart_rd_en", 32'(bus.rd_en),   32'd1);
    check_eq("t3_restart_addr",  32'(bus.rd_addr), 32'd0);
    wait_done("t3b", 4 * N);
    repeat (8) @(posedge clk);
    #1;
    check_eq("t3_no_third", 32'(busy), 32'd0);
    check_eq("t3_left", 32'(q.size()), 32'd0);

    // Asynchronous reset with a read in flight
    base = hs_count;
    pulse_start(1'b1);
    wait_hs(base + 100, 4 * N);
    check_eq("t4_rd_en_pre", 32'(bus.rd_en), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_idle("t4_async");
    q.delete();
    @(posedge clk); #1;
    check_idle("t4_held");
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("t4_idle_after", 32'(bus.out_valid), 32'd0);
    pulse_start(1'b1);
    check_eq("t4_restart_addr",  32'(bus.rd_addr), 32'd0);
    check_eq("t4_restart_rd_en", 32'(bus.rd_en),   32'd1);
    wait_done("t4", 4 * N);
    check_eq("t4_left", 32'(q.size()), 32'd0);
    @(posedge clk); #1;

    // Start request coincident with the final handshake
    base = hs_count;
    pulse_start(1'b1);
    wait_hs(base + N - 1, 4 * N);
    check_eq("t5_last_valid", 32'(bus.out_valid), 32'd1);
    pulse_start(1'b1);
    check_eq("t5_done",     32'(frame_done), 32'd1);
    check_eq("t5_gap_busy", 32'(busy),       32'd0);
    @(posedge clk); #1;
    check_eq("t5_restart_addr", 32'(bus.rd_addr), 32'd0);
    check_eq("t5_restart_busy", 32'(busy),        32'd1);
    wait_done("t5b", 4 * N);
    check_eq("t5_count", 32'(hs_count - base), 32'(2 * N));
    check_eq("t5_left",  32'(q.size()), 32'd0);

    repeat (4) @(posedge clk);
    #1;
    check_eq("end_idle", 32'(busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
